// File: rtl/scanline_fetch.sv
// Scanline fetch engine: streams a run of words from the graphics memory port
// into a small line FIFO, throttling requests so the FIFO can never overflow.
module scanline_fetch #(
    parameter int unsigned BITS         = 16,
    parameter int unsigned ADDRESS_BITS = 15,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    input  logic [ADDRESS_BITS-1:0] BASE_ADDR,
    input  logic [8:0]              WORD_COUNT,
    output logic [ADDRESS_BITS-1:0] GFX_ADDRESS,
    output logic                    GFX_REQ,
    output logic                    GFX_WR,
    output logic [BITS-1:0]         GFX_DATA_IN,
    input  logic [BITS-1:0]         MEM_DATA,
    output logic [BITS-1:0]         RD_DATA,
    output logic                    RD_VALID,
    input  logic                    RD_READY,
    output logic                    BUSY,
    output logic                    DONE
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned CMP_W = CNT_W + 1;
    localparam int unsigned WC_W  = 9;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FINISH} state_t;

    state_t                  state_q, state_d;
    logic [ADDRESS_BITS-1:0] addr_q, addr_d;
    logic [WC_W-1:0]         remaining_q, remaining_d;
    logic                    inflight_q;
    logic                    req;
    logic                    has_room;

    logic [BITS-1:0]         fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic                    push, pop, full;

    // Words already stored plus the one still on the memory bus must fit.
    assign has_room = (CMP_W'(count_q) + CMP_W'(inflight_q)) < CMP_W'(FIFO_DEPTH);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= req;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        req         = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    if (WORD_COUNT != '0) begin
                        addr_d      = BASE_ADDR;
                        remaining_d = WORD_COUNT;
                        state_d     = FETCH;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            FETCH: begin
                if (remaining_q != '0 && has_room) begin
                    req         = 1'b1;
                    addr_d      = addr_q + ADDRESS_BITS'(1);
                    remaining_d = remaining_q - WC_W'(1);
                    if (remaining_q == WC_W'(1)) state_d = DRAIN;
                end
            end
            // The final word is on the bus now and lands at the end of this cycle.
            DRAIN:   state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign GFX_ADDRESS = addr_q;
    assign GFX_REQ     = req;
    assign GFX_WR      = 1'b0;
    assign GFX_DATA_IN = '0;
    assign BUSY        = (state_q != IDLE);
    assign DONE        = (state_q == FINISH);

    assign push     = inflight_q;
    assign pop      = RD_READY && RD_VALID;
    assign full     = (count_q == CNT_W'(FIFO_DEPTH));
    assign RD_VALID = (count_q != '0);
    assign RD_DATA  = RD_VALID ? fifo_mem[rd_ptr_q] : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_q] <= MEM_DATA;
                wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge CLK) disable iff (RST) !(push && !pop && full));

endmodule

// File: tb/tb_scanline_fetch.sv
// Directed bench for scanline_fetch: a table of fetch transfers checked against
// a memory model, plus hand-written reset sequences.
module tb_scanline_fetch;

    logic        CLK;
    logic        RST;
    logic        START;
    logic [14:0] BASE_ADDR;
    logic [8:0]  WORD_COUNT;
    logic [14:0] GFX_ADDRESS;
    logic        GFX_REQ;
    logic        GFX_WR;
    logic [15:0] GFX_DATA_IN;
    logic [15:0] MEM_DATA;
    logic [15:0] RD_DATA;
    logic        RD_VALID;
    logic        RD_READY;
    logic        BUSY;
    logic        DONE;

    scanline_fetch dut (
        .CLK(CLK), .RST(RST), .START(START), .BASE_ADDR(BASE_ADDR),
        .WORD_COUNT(WORD_COUNT), .GFX_ADDRESS(GFX_ADDRESS), .GFX_REQ(GFX_REQ),
        .GFX_WR(GFX_WR), .GFX_DATA_IN(GFX_DATA_IN), .MEM_DATA(MEM_DATA),
        .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .RD_READY(RD_READY),
        .BUSY(BUSY), .DONE(DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // mode: 0 ready held 1, 1 ready alternating, 2 ready 0 until cycle 30, 3 ready 1 + stray START
    typedef struct {
        logic [14:0] base;
        int          cnt;
        int          mode;
        int          exp_lat;
    } vec_t;

    vec_t        vecs [8];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [14:0] req_q [$];
    logic [15:0] got_q [$];
    int          cyc, done_cnt, done_cyc, busy_cycles, first_pop, last_pop;
    logic        prev_done;

    function automatic logic [15:0] mem_word(input logic [14:0] a);
        return {1'b1, a} ^ 16'h3C5A;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Observe one clock cycle, then answer any request with next-cycle memory data.
    task automatic step();
        logic        rq;
        logic [14:0] ra;
        rq = GFX_REQ;
        ra = GFX_ADDRESS;
        if (GFX_REQ) req_q.push_back(GFX_ADDRESS);
        if (RD_VALID && RD_READY) begin
            if (got_q.size() == 0) first_pop = cyc;
            last_pop = cyc;
            got_q.push_back(RD_DATA);
        end
        if (BUSY) busy_cycles++;
        if (DONE) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_done) check("busy_after_done", int'(BUSY), 0);
        prev_done = DONE;
        @(posedge CLK);
        #1;
        MEM_DATA = rq ? mem_word(ra) : 16'h0;
        cyc++;
    endtask

    task automatic clear_obs();
        req_q.delete();
        got_q.delete();
        cyc = 0; done_cnt = 0; done_cyc = -1; busy_cycles = 0;
        first_pop = -1; last_pop = -1; prev_done = 1'b0;
    endtask

    task automatic run_vector(input vec_t v);
        logic finished;
        finished = 1'b0;
        clear_obs();
        START      = 1'b1;
        BASE_ADDR  = v.base;
        WORD_COUNT = 9'(v.cnt);
        RD_READY   = (v.mode == 0 || v.mode == 3);
        step();
        START = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done_cnt > 0 && !prev_done && got_q.size() >= v.cnt && !RD_VALID) begin
                finished = 1'b1;
                break;
            end
            case (v.mode)
                1:       RD_READY = cyc[0];
                2:       RD_READY = (cyc >= 30);
                default: RD_READY = 1'b1;
            endcase
            START = (v.mode == 3 && cyc == 3);
            if (v.mode == 2 && cyc == 30) begin
                check("req_cap", req_q.size(), 16);
                check("req_stall", int'(GFX_REQ), 0);
                check("full_valid", int'(RD_VALID), 1);
                check("head_stable", int'(RD_DATA), int'(mem_word(v.base)));
            end
            step();
        end
        START = 1'b0;
        check("finished", int'(finished), 1);
        check("nreq", req_q.size(), v.cnt);
        for (int i = 0; i < req_q.size() && i < v.cnt; i++)
            check("req_addr", int'(req_q[i]), int'(15'(v.base + 15'(i))));
        check("nwords", got_q.size(), v.cnt);
        for (int i = 0; i < got_q.size() && i < v.cnt; i++)
            check("word", int'(got_q[i]), int'(mem_word(15'(v.base + 15'(i)))));
        check("done_cnt", done_cnt, 1);
        if (v.exp_lat != 0) begin
            check("done_lat", done_cyc, v.exp_lat);
            check("busy_cycles", busy_cycles, v.exp_lat);
        end
        if ((v.mode == 0 || v.mode == 3) && v.cnt > 0)
            check("back_to_back", last_pop - first_pop, v.cnt - 1);
    endtask

    initial begin
        vecs[0] = '{15'h0100,   4, 0,  6};
        vecs[1] = '{15'h7FFE,   4, 0,  6};
        vecs[2] = '{15'h0000,   0, 0,  1};
        vecs[3] = '{15'h1234,   1, 0,  3};
        vecs[4] = '{15'h0200,  20, 0, 22};
        vecs[5] = '{15'h0300,  40, 2,  0};
        vecs[6] = '{15'h0400,  10, 3, 12};
        vecs[7] = '{15'h4000, 256, 1,  0};

        RST = 1'b1; START = 1'b0; BASE_ADDR = '0; WORD_COUNT = '0;
        RD_READY = 1'b0; MEM_DATA = '0;
        clear_obs();
        step();
        step();
        check("wr_in_reset", int'(GFX_WR), 0);
        check("wdata_in_reset", int'(GFX_DATA_IN), 0);
        check("rst_req", int'(GFX_REQ), 0);
        check("rst_addr", int'(GFX_ADDRESS), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_done", int'(DONE), 0);
        check("rst_valid", int'(RD_VALID), 0);
        check("rst_data", int'(RD_DATA), 0);
        RST = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_vector(vecs[i]);

        // Reset in the middle of an 8-word fetch, with the 4th request in the reset cycle.
        clear_obs();
        RD_READY   = 1'b0;
        START      = 1'b1;
        BASE_ADDR  = 15'h0500;
        WORD_COUNT = 9'd8;
        step();
        START = 1'b0;
        step(); step(); step();
        check("pre_rst_reqs", req_q.size(), 3);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("mid_rst_req", int'(GFX_REQ), 0);
        check("mid_rst_valid", int'(RD_VALID), 0);
        check("mid_rst_busy", int'(BUSY), 0);
        step();
        check("discard_late_data", int'(RD_VALID), 0);
        run_vector('{15'h0600, 2, 0, 4});

        check("wr_const", int'(GFX_WR), 0);
        check("wdata_const", int'(GFX_DATA_IN), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
